// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives the operands and start; the slave returns the registered results.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, bin,
    input  diff, bout, zero, busy, done
  );

  modport slave (
    input  start, a, b, bin,
    output diff, bout, zero, busy, done
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b - bin one bit per clock, LSB first.
// Results are published with a one-cycle done pulse and held until the next operation completes.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             d_bit;
  logic             br_next;

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  always_comb begin
    d_bit   = a_q[0] ^ b_q[0] ^ br_q;
    br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.bin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        br_d  = br_next;
        res_d = {d_bit, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // Publish on leaving DONE so the outputs and done pulse appear together.
        diff_d  = res_q;
        bout_d  = br_q;
        zero_d  = (res_q == '0);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.zero = zero_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; sampled on the edge that accepts start.
REQ-006 b  input  WIDTH  subtrahend; sampled on the edge that accepts start.
REQ-007 bin  input  1  borrow-in; sampled on the edge that accepts start.
REQ-008 diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-009 bout  output  1  final borrow-out; 1 when a < b + bin as unsigned values.
REQ-010 zero  output  1  1 when diff == 0.
REQ-011 busy  output  1  1 in states RUN and DONE.
REQ-012 done  output  1  one-cycle pulse; diff, bout and zero are valid and final.

Function
REQ-013 FSM states: IDLE, RUN, DONE; all outputs are registered.
REQ-014 IDLE -> RUN on a clock edge with start=1: load a and b into shift registers, load the borrow register with bin, clear the bit counter, clear the result register.
REQ-015 RUN: each edge processes one bit, LSB first, using full-subtractor logic.
REQ-016 Difference bit: d = a0 ^ b0 ^ br.
REQ-017 Next borrow: br' = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-018 On each RUN edge, shift d into the result MSB (right shift) and shift the a and b registers right by one.
REQ-019 RUN -> DONE on the edge that processes bit WIDTH-1, i.e. after exactly WIDTH RUN edges.
REQ-020 In DONE:
- done=1 for exactly one cycle.
- diff = result register.
- bout = final borrow.
- zero = (diff == 0).
REQ-021 DONE -> IDLE unconditionally on the next edge.
REQ-022 Latency: if start is accepted at edge E, done is high in the cycle following edge E+WIDTH+1.
REQ-023 Result hold: diff, bout and zero keep their values through IDLE until the next DONE.
REQ-024 start while busy=1 (RUN or DONE) is ignored, with no effect on the operation in flight.
REQ-025 Changes on a, b and bin after acceptance do not affect the result.
REQ-026 start held high continuously: a new operation is accepted on the first IDLE edge after DONE; back-to-back throughput is one result per WIDTH+2 cycles.
REQ-027 Arithmetic is unsigned modulo 2^WIDTH. For signed use, diff is the two's-complement difference, and bout is not an overflow flag.

Reset
REQ-028 rst=1 on an edge forces IDLE and clears to 0: diff, bout, zero, busy, done, the borrow register, the counter and the shift registers.
REQ-029 rst has priority over start and over any in-progress operation.
REQ-030 Reset mid-RUN: the partial result is discarded and done does not pulse for the aborted operation.
REQ-031 The first start after rst deasserts is accepted on the first edge with rst=0.

Verification (WIDTH=8)
REQ-032 a=0x05, b=0x03, bin=0, start pulse -> done after 9 edges; diff=0x02, bout=0, zero=0.
REQ-033 a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, zero=0; a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
REQ-034 a=0xFF, b=0xFF, bin=0 -> diff=0x00, bout=0, zero=1; a=0x80, b=0x7F, bin=1 -> diff=0x00, bout=0, zero=1.
REQ-035 Accept a=0x10, b=0x01, then pulse start with a=0x00 mid-RUN -> single done, diff=0x0F; the second start is ignored.
REQ-036 Assert rst at the fourth RUN edge -> next cycle busy=0, done=0, diff=0x00; no done pulse until a new start.
REQ-037 Random sweep of 1000 operands with start held high -> each done result equals (a - b - bin) mod 256 with matching bout; done spacing is exactly 10 cycles.
